// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu execution units.
package cpu_pkg;

  // ALU operation codes; encoding 4'hF is unused and behaves as a no-op pass-through.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_ADC = 4'h1,
    OP_SUB = 4'h2,
    OP_SBC = 4'h3,
    OP_CMP = 4'h4,
    OP_AND = 4'h5,
    OP_ORA = 4'h6,
    OP_EOR = 4'h7,
    OP_ASL = 4'h8,
    OP_LSR = 4'h9,
    OP_ROL = 4'hA,
    OP_ROR = 4'hB,
    OP_INC = 4'hC,
    OP_DEC = 4'hD,
    OP_BIT = 4'hE
  } alu_op_t;

  // Bit positions inside the {N,V,Z,C} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Sequencer states of the ALU.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BCD  = 1'b1
  } alu_state_t;

  // Register widths the core actually instantiates.
  function automatic bit width_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/cpu_bcd_digit.sv
// One BCD digit of a decimal add or subtract, purely combinational.
module cpu_bcd_digit
  import cpu_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_sub,
  output logic [3:0] o_d,
  output logic       o_cout
);

  logic [3:0] b_eff;
  logic [4:0] raw;

  // Binary nibble sum, then the decimal adjust: +6 on decimal carry, -6 on borrow.
  always_comb begin
    b_eff  = i_sub ? ~i_b : i_b;
    raw    = {1'b0, i_a} + {1'b0, b_eff} + {4'b0000, i_cin};
    o_d    = raw[3:0];
    o_cout = raw[4];
    if (!i_sub) begin
      if (raw > 5'd9) begin
        o_d    = raw[3:0] + 4'd6;
        o_cout = 1'b1;
      end else begin
        o_cout = 1'b0;
      end
    end else if (!raw[4]) begin
      o_d    = raw[3:0] - 4'd6;
      o_cout = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// Width-generic ALU: single-cycle binary ops, nibble-serial decimal ADC/SBC,
// registered valid/ready response port.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_flags,
  input  logic             i_decimal,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_busy
);

  localparam int MSB    = WIDTH - 1;
  localparam int DIGITS = WIDTH / 4;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("cpu_alu: WIDTH must be 8, 16 or 32");
  end

  function automatic logic [3:0] set_nz(input logic [3:0] f, input logic [WIDTH-1:0] r);
    logic [3:0] o;
    o         = f;
    o[FLAG_N] = r[MSB];
    o[FLAG_Z] = (r == '0);
    return o;
  endfunction

  alu_op_t          op;
  alu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic             slot_free, dec_req;
  logic             acc_bin, acc_dec, bcd_done, busy, req_ready;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [WIDTH-1:0] bin_res, nz_src;
  logic [3:0]       bin_flags;
  logic             upd_nz;

  logic [WIDTH-1:0] a_sh_p0, b_sh_p0, res_sh_p0;
  logic             carry_p0, sub_p0, v_p0;
  logic [3:0]       dig_d;
  logic             dig_cout;
  logic [WIDTH-1:0] bcd_res;
  logic [3:0]       bcd_flags;

  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic [3:0]       flags_p1;

  assign op        = alu_op_t'(i_op);
  assign slot_free = !vld_p1 || i_rsp_ready;
  assign dec_req   = DECIMAL_EN && i_decimal && ((op == OP_ADC) || (op == OP_SBC));

  // Shared WIDTH+1 adder: subtraction adds the inverted operand.
  always_comb begin
    add_b   = i_b;
    add_cin = 1'b0;
    case (op)
      OP_ADC:         add_cin = i_flags[FLAG_C];
      OP_SUB, OP_CMP: begin
        add_b   = ~i_b;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_b   = ~i_b;
        add_cin = i_flags[FLAG_C];
      end
      default: ;
    endcase
    sum   = {1'b0, i_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_v = (i_a[MSB] == add_b[MSB]) && (sum[MSB] != i_a[MSB]);
  end

  // Binary result and flags; flags not touched by an op pass through.
  always_comb begin
    bin_res   = i_a;
    bin_flags = i_flags;
    upd_nz    = 1'b1;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        bin_res           = sum[WIDTH-1:0];
        bin_flags[FLAG_V] = add_v;
        bin_flags[FLAG_C] = sum[WIDTH];
      end
      OP_CMP: bin_flags[FLAG_C] = sum[WIDTH];
      OP_AND: bin_res = i_a & i_b;
      OP_ORA: bin_res = i_a | i_b;
      OP_EOR: bin_res = i_a ^ i_b;
      OP_ASL: begin
        bin_res           = {i_a[MSB-1:0], 1'b0};
        bin_flags[FLAG_C] = i_a[MSB];
      end
      OP_LSR: begin
        bin_res           = {1'b0, i_a[MSB:1]};
        bin_flags[FLAG_C] = i_a[0];
      end
      OP_ROL: begin
        bin_res           = {i_a[MSB-1:0], i_flags[FLAG_C]};
        bin_flags[FLAG_C] = i_a[MSB];
      end
      OP_ROR: begin
        bin_res           = {i_flags[FLAG_C], i_a[MSB:1]};
        bin_flags[FLAG_C] = i_a[0];
      end
      OP_INC: bin_res = i_a + 1'b1;
      OP_DEC: bin_res = i_a - 1'b1;
      OP_BIT: begin
        upd_nz            = 1'b0;
        bin_flags[FLAG_Z] = ((i_a & i_b) == '0);
        bin_flags[FLAG_N] = i_b[MSB];
        bin_flags[FLAG_V] = i_b[MSB-1];
      end
      default: upd_nz = 1'b0;
    endcase
    nz_src = (op == OP_CMP) ? sum[WIDTH-1:0] : bin_res;
    if (upd_nz) begin
      bin_flags = set_nz(bin_flags, nz_src);
    end
  end

  // Sequencer next state, handshake and accept decode.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    acc_bin   = 1'b0;
    acc_dec   = 1'b0;
    bcd_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = slot_free && !i_rst;
        if (i_req_valid && req_ready) begin
          if (dec_req) begin
            acc_dec = 1'b1;
            state_d = S_BCD;
          end else begin
            acc_bin = 1'b1;
          end
        end
      end
      S_BCD: begin
        busy = !i_rst;
        if (cnt_q == LAST_DIGIT) begin
          bcd_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_req_ready = req_ready;
  assign o_busy      = busy;

  // State register and digit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc_dec || bcd_done) begin
        cnt_q <= '0;
      end else if (state_q == S_BCD) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // ---- p0: decimal digit stage, operands shifted one nibble per cycle ----
  cpu_bcd_digit u_digit (
    .i_a    (a_sh_p0[3:0]),
    .i_b    (b_sh_p0[3:0]),
    .i_cin  (carry_p0),
    .i_sub  (sub_p0),
    .o_d    (dig_d),
    .o_cout (dig_cout)
  );

  assign bcd_res   = {dig_d, res_sh_p0[WIDTH-1:4]};
  assign bcd_flags = {bcd_res[MSB], v_p0, (bcd_res == '0), dig_cout};

  // Latch operands on decimal accept, then walk the digits LSD first.
  always_ff @(posedge i_clk) begin
    if (acc_dec) begin
      a_sh_p0  <= i_a;
      b_sh_p0  <= i_b;
      carry_p0 <= i_flags[FLAG_C];
      sub_p0   <= (op == OP_SBC);
      v_p0     <= add_v;
    end else if (state_q == S_BCD) begin
      a_sh_p0   <= a_sh_p0 >> 4;
      b_sh_p0   <= b_sh_p0 >> 4;
      carry_p0  <= dig_cout;
      res_sh_p0 <= bcd_res;
    end
  end

  // ---- p1: response register, held until the consumer takes it ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else if (acc_bin) begin
      vld_p1    <= 1'b1;
      result_p1 <= bin_res;
      flags_p1  <= bin_flags;
    end else if (bcd_done) begin
      vld_p1    <= 1'b1;
      result_p1 <= bcd_res;
      flags_p1  <= bcd_flags;
    end else if (vld_p1 && i_rsp_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign o_rsp_valid = vld_p1;
  assign o_result    = result_p1;
  assign o_flags     = flags_p1;

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: an 8-bit and a 32-bit instance against a
// arithmetic reference model, directed vectors plus randomized traffic.
module tb_cpu_alu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_s;
  logic [31:0] a_s, b_s;
  logic [3:0]  fl_s;
  logic        dec_s;
  logic        rsp_rdy;
  logic        vld8, vld32;
  logic        rdy8, rv8, busy8;
  logic [7:0]  res8;
  logic [3:0]  fo8;
  logic        rdy32, rv32, busy32;
  logic [31:0] res32;
  logic [3:0]  fo32;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_alu #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld8), .o_req_ready(rdy8),
    .i_op(op_s), .i_a(a_s[7:0]), .i_b(b_s[7:0]), .i_flags(fl_s), .i_decimal(dec_s),
    .o_rsp_valid(rv8), .i_rsp_ready(rsp_rdy), .o_result(res8), .o_flags(fo8), .o_busy(busy8)
  );

  cpu_alu #(.WIDTH(32), .DECIMAL_EN(1'b1)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld32), .o_req_ready(rdy32),
    .i_op(op_s), .i_a(a_s), .i_b(b_s), .i_flags(fl_s), .i_decimal(dec_s),
    .o_rsp_valid(rv32), .i_rsp_ready(rsp_rdy), .o_result(res32), .o_flags(fo32), .o_busy(busy32)
  );

  // ---------------- reference model ----------------
  function automatic longint to_dec(input longint v, input int nd);
    longint d, p;
    d = 0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      d += ((v >> (4 * i)) & 15) * p;
      p *= 10;
    end
    return d;
  endfunction

  function automatic longint to_bcd(input longint v, input int nd);
    longint r, t;
    r = 0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r |= (t % 10) << (4 * i);
      t /= 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int nd);
    longint p;
    p = 1;
    for (int i = 0; i < nd; i++) p *= 10;
    return p;
  endfunction

  // Returns {N,V,Z,C, result[31:0]}.
  function automatic logic [35:0] model(input int w, input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] f, input bit dec);
    longint mask, half, ua, ub, bp, ci, s, sv, r, t, lim, nzv;
    bit n, v, z, c, oc, upd;
    int nd;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    n = f[3]; v = f[2]; z = f[1]; c = f[0];
    oc  = c;
    r   = ua;
    nzv = ua;
    upd = 1'b1;
    nd  = w / 4;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        bp = (op inside {OP_SUB, OP_SBC, OP_CMP}) ? (~ub & mask) : ub;
        ci = (op == OP_ADD) ? 0 : (op inside {OP_SUB, OP_CMP}) ? 1 : longint'(oc);
        s  = ua + bp + ci;
        sv = ((ua >= half) ? ua - 2 * half : ua) + ((bp >= half) ? bp - 2 * half : bp) + ci;
        c  = ((s >> w) & 1) != 0;
        nzv = s & mask;
        if (op == OP_CMP) begin
          r = ua;
        end else begin
          v = (sv >= half) || (sv < -half);
          r = nzv;
        end
        if (dec && (op == OP_ADC || op == OP_SBC)) begin
          lim = pow10(nd);
          if (op == OP_ADC) begin
            t = to_dec(ua, nd) + to_dec(ub, nd) + ci;
            c = t >= lim;
            t = t % lim;
          end else begin
            t = to_dec(ua, nd) - to_dec(ub, nd) - (1 - ci);
            c = t >= 0;
            if (t < 0) t += lim;
          end
          r   = to_bcd(t, nd);
          nzv = r;
        end
      end
      OP_AND: begin r = ua & ub; nzv = r; end
      OP_ORA: begin r = ua | ub; nzv = r; end
      OP_EOR: begin r = ua ^ ub; nzv = r; end
      OP_ASL: begin c = (ua & half) != 0; r = (ua * 2) & mask; nzv = r; end
      OP_LSR: begin c = (ua & 1) != 0; r = ua / 2; nzv = r; end
      OP_ROL: begin c = (ua & half) != 0; r = ((ua * 2) + longint'(oc)) & mask; nzv = r; end
      OP_ROR: begin c = (ua & 1) != 0; r = (ua / 2) + (oc ? half : 0); nzv = r; end
      OP_INC: begin r = (ua + 1) & mask; nzv = r; end
      OP_DEC: begin r = (ua + mask) & mask; nzv = r; end
      OP_BIT: begin
        upd = 1'b0;
        z = (ua & ub) == 0;
        n = (ub & half) != 0;
        v = (ub & (half / 2)) != 0;
      end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      n = (nzv & half) != 0;
      z = nzv == 0;
    end
    return {n, v, z, c, 32'(r)};
  endfunction

  // ---------------- driver ----------------
  // Presents one request, waits for acceptance, then counts edges until the
  // response appears. lat = -1 when acceptance or response never came.
  task automatic do_op(input bit wide, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] fl, input bit dec,
                       output logic [31:0] res, output logic [3:0] flo,
                       output int lat, output int busy_cnt);
    bit acc;
    int n;
    op_s = op; a_s = a; b_s = b; fl_s = fl; dec_s = dec;
    if (wide) vld32 = 1'b1;
    else      vld8  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = wide ? rdy32 : rdy8;
      @(posedge clk);
      n++;
    end
    #1;
    vld8  = 1'b0;
    vld32 = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    n        = 0;
    while (acc && lat < 0 && n < 20) begin
      if (wide ? rv32 : rv8) begin
        lat = n;
      end else begin
        busy_cnt += int'(wide ? busy32 : busy8);
        @(posedge clk);
        #1;
        n++;
      end
    end
    res = wide ? res32 : {24'h0, res8};
    flo = wide ? fo32 : fo8;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; vld8 = 1'b0; vld32 = 1'b0; rsp_rdy = 1'b1;
    op_s = 4'h0; a_s = '0; b_s = '0; fl_s = '0; dec_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rdy8, rdy32} !== 2'b00) begin
      bad++; $display("FAIL reset_ready_low: got %b%b want 00", rdy8, rdy32);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy8, rdy32} !== 2'b11) begin
      bad++; $display("FAIL ready_after_release: got %b%b want 11", rdy8, rdy32);
    end
    total++;
    if ({rv8, busy8, fo8, res8} !== 14'd0) begin
      bad++; $display("FAIL reset_state8: v=%b busy=%b f=%h r=%h want all 0", rv8, busy8, fo8, res8);
    end
    total++;
    if ({rv32, busy32, fo32, res32} !== 38'd0) begin
      bad++; $display("FAIL reset_state32: v=%b busy=%b f=%h r=%h want all 0", rv32, busy32, fo32, res32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, bc;
    do_op(1'b0, OP_ADC, 32'h50, 32'h50, 4'b0000, 1'b0, r, f, lat, bc);
    total++;
    if ({lat, f, r} !== {32'sd0, 4'b1100, 32'h000000A0}) begin
      bad++; $display("FAIL adc_50_50: lat=%0d f=%b r=%h want lat=0 f=1100 r=a0", lat, f, r);
    end
    do_op(1'b0, OP_SBC, 32'h00, 32'h01, 4'b0001, 1'b0, r, f, lat, bc);
    total++;
    if ({lat, f, r} !== {32'sd0, 4'b1000, 32'h000000FF}) begin
      bad++; $display("FAIL sbc_00_01: lat=%0d f=%b r=%h want lat=0 f=1000 r=ff", lat, f, r);
    end
    do_op(1'b0, OP_CMP, 32'h40, 32'h40, 4'b0100, 1'b0, r, f, lat, bc);
    total++;
    if ({f, r} !== {4'b0111, 32'h00000040}) begin
      bad++; $display("FAIL cmp_equal: f=%b r=%h want f=0111 r=40", f, r);
    end
    do_op(1'b0, OP_ROR, 32'h01, 32'h00, 4'b0001, 1'b0, r, f, lat, bc);
    total++;
    if ({f, r} !== {4'b1001, 32'h00000080}) begin
      bad++; $display("FAIL ror_carry_in: f=%b r=%h want f=1001 r=80", f, r);
    end
    do_op(1'b0, OP_BIT, 32'h0F, 32'hC0, 4'b0001, 1'b0, r, f, lat, bc);
    total++;
    if ({f, r} !== {4'b1111, 32'h0000000F}) begin
      bad++; $display("FAIL bit_0f_c0: f=%b r=%h want f=1111 r=0f", f, r);
    end
    do_op(1'b0, OP_ADC, 32'h58, 32'h46, 4'b0001, 1'b1, r, f, lat, bc);
    total++;
    if ({lat, f, r} !== {32'sd2, 4'b0101, 32'h00000005}) begin
      bad++; $display("FAIL dec_adc_58_46: lat=%0d f=%b r=%h want lat=2 f=0101 r=05", lat, f, r);
    end
  endtask

  task automatic test_decimal32();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, bc;
    do_op(1'b1, OP_ADC, 32'h99999999, 32'h00000001, 4'b0000, 1'b1, r, f, lat, bc);
    total++;
    if ({f, r} !== {4'b0011, 32'h00000000}) begin
      bad++; $display("FAIL dec32_wrap: f=%b r=%h want f=0011 r=00000000", f, r);
    end
    total++;
    if (lat !== 8 || bc !== 8) begin
      bad++; $display("FAIL dec32_timing: lat=%0d busy=%0d want lat=8 busy=8", lat, bc);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, exp_r;
    logic [3:0]  f, fl, op;
    logic [35:0] m;
    int          lat, bc, w, exp_lat;
    bit          wide, dec;
    for (int i = 0; i < 160; i++) begin
      wide = (i % 3) == 2;
      w    = wide ? 32 : 8;
      op   = 4'($urandom_range(0, 14));
      dec  = 1'($urandom_range(0, 1));
      fl   = 4'($urandom);
      a    = $urandom;
      b    = $urandom;
      if (dec && (op == OP_ADC || op == OP_SBC)) begin
        a = 32'(to_bcd(longint'($urandom_range(0, 32'(pow10(w / 4) - 1))), w / 4));
        b = 32'(to_bcd(longint'($urandom_range(0, 32'(pow10(w / 4) - 1))), w / 4));
      end
      m       = model(w, op, a, b, fl, dec);
      exp_r   = wide ? m[31:0] : {24'h0, m[7:0]};
      exp_lat = (dec && (op == OP_ADC || op == OP_SBC)) ? w / 4 : 0;
      do_op(wide, op, a, b, fl, dec, r, f, lat, bc);
      total++;
      if ({f, r} !== {m[35:32], exp_r}) begin
        bad++;
        $display("FAIL rand_%0d w=%0d op=%0d d=%b a=%h b=%h fin=%b: got f=%b r=%h want f=%b r=%h",
                 i, w, op, dec, a, b, fl, f, r, m[35:32], exp_r);
      end
      total++;
      if (lat !== exp_lat) begin
        bad++; $display("FAIL rand_lat_%0d w=%0d op=%0d d=%b: got %0d want %0d", i, w, op, dec, lat, exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [3:0]  f, hold_f;
    logic [7:0]  hold_r;
    logic [35:0] m;
    int          lat, bc;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    m = model(8, OP_EOR, 32'h5A, 32'hFF, 4'b0000, 1'b0);
    do_op(1'b0, OP_EOR, 32'h5A, 32'hFF, 4'b0000, 1'b0, r, f, lat, bc);
    total++;
    if ({lat, f, r[7:0]} !== {32'sd0, m[35:32], m[7:0]}) begin
      bad++; $display("FAIL bp_first: lat=%0d f=%b r=%h want lat=0 f=%b r=%h", lat, f, r[7:0], m[35:32], m[7:0]);
    end
    hold_r = res8;
    hold_f = fo8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rdy8 !== 1'b0) begin
        bad++; $display("FAIL bp_ready_%0d: got %b want 0", k, rdy8);
      end
      @(posedge clk); #1;
      total++;
      if ({rv8, fo8, res8} !== {1'b1, hold_f, hold_r}) begin
        bad++; $display("FAIL bp_hold_%0d: v=%b f=%b r=%h want v=1 f=%b r=%h", k, rv8, fo8, res8, hold_f, hold_r);
      end
    end
    rsp_rdy = 1'b1;
    op_s    = OP_ADD;
    dec_s   = 1'b0;
    vld8    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_s  = $urandom;
      b_s  = $urandom;
      fl_s = 4'($urandom);
      m    = model(8, OP_ADD, a_s, b_s, fl_s, 1'b0);
      @(negedge clk);
      total++;
      if (rdy8 !== 1'b1) begin
        bad++; $display("FAIL b2b_ready_%0d: got %b want 1", k, rdy8);
      end
      @(posedge clk); #1;
      total++;
      if ({rv8, fo8, res8} !== {1'b1, m[35:32], m[7:0]}) begin
        bad++; $display("FAIL b2b_rsp_%0d: v=%b f=%b r=%h want v=1 f=%b r=%h", k, rv8, fo8, res8, m[35:32], m[7:0]);
      end
    end
    vld8 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rv8 !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: valid=%b want 0", rv8);
    end
  endtask

  task automatic test_reset_mid_decimal();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, bc;
    bit          seen;
    @(posedge clk); #1;
    op_s = OP_ADC; a_s = 32'h12345678; b_s = 32'h11111111; fl_s = 4'b0000; dec_s = 1'b1;
    vld32 = 1'b1;
    @(negedge clk);
    total++;
    if (rdy32 !== 1'b1) begin
      bad++; $display("FAIL mid_accept_ready: got %b want 1", rdy32);
    end
    @(posedge clk); #1;
    vld32 = 1'b0;
    total++;
    if (busy32 !== 1'b1) begin
      bad++; $display("FAIL mid_busy_started: got %b want 1", busy32);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy32, rv32} !== 2'b00) begin
      bad++; $display("FAIL mid_abort: busy=%b valid=%b want 0 0", busy32, rv32);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rv32) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL mid_no_response: a response appeared after abort, want none");
    end
    do_op(1'b1, OP_ADD, 32'd1, 32'd1, 4'b0000, 1'b0, r, f, lat, bc);
    total++;
    if ({lat, r} !== {32'sd0, 32'h00000002}) begin
      bad++; $display("FAIL mid_followup_add: lat=%0d r=%h want lat=0 r=00000002", lat, r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_decimal32();
    test_back_to_back();
    test_random();
    test_reset_mid_decimal();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
